// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci request sequencer.
// FSM state encoding, default widths and requester IDs.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FIB_WIDTH = 32;
    localparam int FIB_IDX_W = 6;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/fib_step_core.sv
// Fibonacci generator datapath with clear/step control.
// Ports: clk, rst (sync, active-high), clr, step -> a = F(k), ovf_a.
module fib_step_core
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    output logic [WIDTH-1:0] a,
    output logic             ovf_a
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_ovf_a;
    logic             r_ovf_b;
    logic [WIDTH:0]   w_sum;

    // Extra MSB of the sum is the carry out of a+b.
    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_a     <= '0;
            r_b     <= WIDTH'(1);
            r_ovf_a <= 1'b0;
            r_ovf_b <= 1'b0;
        end else if (step) begin
            r_a     <= r_b;
            r_b     <= w_sum[WIDTH-1:0];
            // ovf_b tracks b = F(k+1); it becomes ovf_a as b moves to a.
            r_ovf_b <= r_ovf_b | w_sum[WIDTH];
            r_ovf_a <= r_ovf_b;
        end
    end

    assign a     = r_a;
    assign ovf_a = r_ovf_a;

endmodule

// File: rtl/fib_seq_ctrl.sv
// Round-robin request scheduler and sequencer for a shared Fibonacci core.
// Ports: two req valid/ready/n channels, one rsp valid/ready/data/ovf/id, busy.
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int IDX_W = FIB_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [IDX_W-1:0] req0_n,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [IDX_W-1:0] req1_n,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_ovf,
    output logic             rsp_id,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_cnt;
    logic             r_id;
    logic             r_last_grant;

    logic             w_gnt_id;
    logic             w_accept;
    logic [IDX_W-1:0] w_n;
    logic             w_clr;
    logic             w_step;
    logic             w_rsp_hs;

    // Tie goes to the requester not served last.
    assign w_gnt_id = (req0_valid && req1_valid) ? ~r_last_grant
                    : (req1_valid ? REQ1 : REQ0);
    assign w_accept = (r_state == IDLE) && (req0_valid || req1_valid);
    assign w_n      = (w_gnt_id == REQ1) ? req1_n : req0_n;
    assign w_rsp_hs = (r_state == DONE) && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (w_n != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (r_cnt == IDX_W'(1)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        w_clr      = 1'b0;
        w_step     = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy       = 1'b0;
                req0_ready = req0_valid && (w_gnt_id == REQ0);
                req1_ready = req1_valid && (w_gnt_id == REQ1);
                w_clr      = w_accept;
            end
            RUN:  w_step    = 1'b1;
            DONE: rsp_valid = 1'b1;
            default: busy   = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_id         <= REQ0;
            r_last_grant <= REQ1;
        end else begin
            if (w_accept) begin
                r_cnt <= w_n;
                r_id  <= w_gnt_id;
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt - IDX_W'(1);
            end
            if (w_rsp_hs) begin
                r_last_grant <= r_id;
            end
        end
    end

    fib_step_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .step  (w_step),
        .a     (rsp_data),
        .ovf_a (rsp_ovf)
    );

    assign rsp_id = r_id;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed self-checking bench for fib_seq_ctrl.
// Hand-computed Fibonacci terms, latencies and grant order.
module tb_fib_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid;
    logic [5:0]  req0_n;
    logic        req0_ready;
    logic        req1_valid;
    logic [5:0]  req1_n;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_ovf;
    logic        rsp_id;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fib_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_n     (req0_n),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_n     (req1_n),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_ovf    (rsp_ovf),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input logic id);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                ok = 1;
                break;
            end
        end
        chk("ready_seen", 64'(ok), 64'd1);
    endtask

    // Entered just after the accepting edge.
    task automatic wait_rsp(input logic id, input int n,
                            input logic [31:0] d, input logic o);
        int lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        chk("latency", 64'(lat), 64'(n + 1));
        chk("rsp_data", 64'(rsp_data), 64'(d));
        chk("rsp_ovf", 64'(rsp_ovf), 64'(o));
        chk("rsp_id", 64'(rsp_id), 64'(id));
        @(posedge clk);
        #1;
    endtask

    task automatic finish_req(input logic id, input int n,
                              input logic [31:0] d, input logic o);
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
        wait_rsp(id, n, d, o);
    endtask

    task automatic send(input logic id, input int n,
                        input logic [31:0] d, input logic o);
        if (id) begin
            req1_n = 6'(n); req1_valid = 1'b1;
        end else begin
            req0_n = 6'(n); req0_valid = 1'b1;
        end
        wait_ready(id);
        finish_req(id, n, d, o);
    endtask

    initial begin
        logic [31:0] hd;
        logic        ho;
        logic        hi;
        bit          seen;
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_n     = 6'd3;
        req1_valid = 1'b0;
        req1_n     = 6'd0;
        rsp_ready  = 1'b1;

        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 64'(rsp_valid), 64'd0);
        chk("post_rst_data", 64'(rsp_data), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_ready0", 64'(req0_ready), 64'd1);
        finish_req(1'b0, 3, 32'd2, 1'b0);

        send(1'b0, 0, 32'd0, 1'b0);
        send(1'b0, 1, 32'd1, 1'b0);
        send(1'b0, 2, 32'd1, 1'b0);
        send(1'b0, 10, 32'd55, 1'b0);
        send(1'b1, 4, 32'd3, 1'b0);

        // Round robin with both held valid; last grant was 1.
        req0_n = 6'd5; req1_n = 6'd5;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            seen = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    seen = 1;
                    break;
                end
            end
            chk("rr_seen", 64'(seen), 64'd1);
            chk("rr_grant", 64'(req1_ready), 64'(k % 2));
            chk("rr_single", 64'(req0_ready & req1_ready), 64'd0);
            @(posedge clk);
            #1;
            wait_rsp(1'((k % 2)), 5, 32'd5, 1'b0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        send(1'b0, 47, 32'd2971215073, 1'b0);
        send(1'b0, 48, 32'd512559680, 1'b1);
        send(1'b0, 3, 32'd2, 1'b0);

        // Backpressure in DONE.
        rsp_ready = 1'b0;
        req0_n = 6'd7; req0_valid = 1'b1;
        wait_ready(1'b0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        chk("bp_valid", 64'(seen), 64'd1);
        chk("bp_data", 64'(rsp_data), 64'd13);
        hd = rsp_data; ho = rsp_ovf; hi = rsp_id;
        req1_n = 6'd6; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("bp_hold_data", 64'(rsp_data), 64'(hd));
            chk("bp_hold_meta", 64'({rsp_ovf, rsp_id}), 64'({ho, hi}));
            chk("bp_readies", 64'({req0_ready, req1_ready}), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        wait_ready(1'b1);
        finish_req(1'b1, 6, 32'd8, 1'b0);

        // Reset during RUN abandons the request.
        req0_n = 6'd20; req0_valid = 1'b1;
        wait_ready(1'b0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("run_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1;
        end
        chk("abandon_no_rsp", 64'(seen), 64'd0);
        send(1'b1, 8, 32'd21, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
